dac_sample_feeder: RTL

Rate-controlled sample source that sits directly upstream of the 8-bit delta-sigma DAC and drives its `data_in`. Buffers 8-bit samples arriving on a valid/ready stream in a small FIFO. Releases one sample per programmable sample period (2^rate_shift clock cycles) and flags underruns. Can optionally linearly interpolate between consecutive samples so the modulator sees a smooth ramp instead of a staircase.

---
 rtl/dac_feed_pkg.sv | 26 ++
 rtl/dac_feed_fifo.sv | 69 ++++++
 rtl/dac_sample_feeder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dac_feed_pkg.sv
// dac_feed_pkg
// Shared types and constants for the DAC sample feeder.
//   SAMPLE_W      : width of one DAC sample (unsigned).
//   SHIFT_MAX     : largest legal rate_shift; also the phase counter width.
//   DEPTH_DEFAULT : default FIFO depth in samples.
//   sample_t      : one DAC sample.
//   clamp_shift() : limits a requested rate_shift to a maximum.
package dac_feed_pkg;

  localparam int SAMPLE_W      = 8;
  localparam int SHIFT_MAX     = 15;
  localparam int DEPTH_DEFAULT = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Requests above max_shift are clamped rather than wrapped, so an
  // out-of-range setting only gives the slowest rate.
  function automatic logic [3:0] clamp_shift(input logic [3:0] rs,
                                             input int         max_shift);
    if (int'(rs) > max_shift) begin
      return 4'(max_shift);
    end
    return rs;
  endfunction

endpackage

// File: rtl/dac_feed_fifo.sv
// dac_feed_fifo
// Synchronous FIFO holding samples between the input stream and the
// rate-controlled output stage. The head entry is presented at all times
// (show-ahead) so the consumer can load it into its own register on pop.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, wr_data     : write request and data (ignored while full)
//   pop               : remove head entry (ignored while empty)
//   rd_data           : current head entry
//   full, empty       : occupancy flags
//   level             : number of stored entries, 0..DEPTH
module dac_feed_fifo #(
  parameter int  DEPTH  = dac_feed_pkg::DEPTH_DEFAULT,
  parameter type elem_t = dac_feed_pkg::sample_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  elem_t                  wr_data,
  input  logic                   pop,
  output elem_t                  rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so that equal indices can be told apart
  // as either empty (MSBs equal) or full (MSBs differ).
  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic        push_ok, pop_ok;

  elem_t mem [DEPTH];

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder
// Rate-controlled sample source feeding the 8-bit delta-sigma DAC. Samples
// arrive on a valid/ready stream, are buffered in a FIFO and released one
// per sample period of 2^rate_shift enabled clock cycles.
// Build option: define DAC_FEED_INTERP_EN to compile in linear
// interpolation between consecutive samples; otherwise the output is a
// zero-order hold of the most recently released sample.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   s_data, s_valid    : input sample stream
//   s_ready            : FIFO not full
//   enable             : run the sample clock (phase/output freeze when low)
//   rate_shift         : period = 2^rate_shift cycles, clamped to SHIFT_MAX,
//                        latched at each sample boundary
//   clr_underrun       : clear the sticky underrun flag
//   data_out           : registered sample to the DAC
//   underrun           : sticky, a boundary found the FIFO empty
//   level              : FIFO occupancy
//   tick               : one-cycle pulse on each sample boundary
module dac_sample_feeder #(
  parameter int DEPTH     = dac_feed_pkg::DEPTH_DEFAULT,
  parameter int SHIFT_MAX = dac_feed_pkg::SHIFT_MAX
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  dac_feed_pkg::sample_t  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   enable,
  input  logic [3:0]             rate_shift,
  input  logic                   clr_underrun,
  output dac_feed_pkg::sample_t  data_out,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level,
  output logic                   tick
);

  import dac_feed_pkg::*;

  localparam int PW = SHIFT_MAX;

  logic [PW-1:0] phase_reg, phase_next;
  logic [PW-1:0] period_last;
  logic [3:0]    rs_reg, rs_next;
  sample_t       target_reg, target_next;
  sample_t       data_out_reg, data_out_next;
  logic          underrun_reg, underrun_next;
  logic          tick_int;

  logic          fifo_full, fifo_empty, fifo_pop;
  sample_t       fifo_head;

  dac_feed_fifo #(
    .DEPTH  (DEPTH),
    .elem_t (sample_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (s_valid),
    .wr_data (s_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // P-1 as a mask of rs ones; for rs == PW this is all ones.
  assign period_last = ~({PW{1'b1}} << rs_reg);
  assign tick_int    = enable && (phase_reg == period_last);
  assign fifo_pop    = tick_int && !fifo_empty;

  always_comb begin
    phase_next    = phase_reg;
    rs_next       = rs_reg;
    target_next   = target_reg;
    underrun_next = underrun_reg;
    if (clr_underrun) underrun_next = 1'b0;
    if (enable) begin
      if (tick_int) begin
        phase_next = '0;
        rs_next    = clamp_shift(rate_shift, SHIFT_MAX);
        if (!fifo_empty) begin
          target_next = fifo_head;
        end else begin
          // Listed after the clear so a coincident event keeps the flag set.
          underrun_next = 1'b1;
        end
      end else begin
        phase_next = phase_reg + PW'(1);
      end
    end
  end

`ifdef DAC_FEED_INTERP_EN
  localparam int PRODW = SAMPLE_W + PW + 1;

  sample_t                  prev_reg, prev_next;
  logic signed [SAMPLE_W:0] delta;
  logic signed [PRODW-1:0]  delta_ext, phase_ext, prod, step;

  assign prev_next = tick_int ? target_reg : prev_reg;

  // Signed step scaled by phase/P. The arithmetic shift floors, which for
  // a falling ramp still never undershoots target because phase < P.
  assign delta     = $signed({1'b0, target_reg}) - $signed({1'b0, prev_reg});
  assign delta_ext = {{(PRODW-SAMPLE_W-1){delta[SAMPLE_W]}}, delta};
  assign phase_ext = {{(PRODW-PW){1'b0}}, phase_reg};
  assign prod      = delta_ext * phase_ext;
  assign step      = prod >>> rs_reg;
  // The true sum lies in [0,255], so modulo-256 addition is exact.
  assign data_out_next = prev_reg + step[SAMPLE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_reg <= '0;
    else        prev_reg <= prev_next;
  end
`else
  assign data_out_next = target_reg;
`endif

  // data_out follows state that already holds while disabled, so it
  // settles and then holds too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg    <= '0;
      rs_reg       <= '0;
      target_reg   <= '0;
      underrun_reg <= 1'b0;
      data_out_reg <= '0;
    end else begin
      phase_reg    <= phase_next;
      rs_reg       <= rs_next;
      target_reg   <= target_next;
      underrun_reg <= underrun_next;
      data_out_reg <= data_out_next;
    end
  end

  assign s_ready  = !fifo_full;
  assign tick     = tick_int;
  assign data_out = data_out_reg;
  assign underrun = underrun_reg;

endmodule
